// File: rtl/lif_pkg.sv
// Shared types and helpers for the LIF neuron scheduler and its update datapath.
package lif_pkg;

  localparam int         V_W   = 8;
  localparam logic [7:0] V_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    EMIT   = 2'd2
  } lif_state_e;

  function automatic logic [V_W-1:0] sat_add(input logic [V_W-1:0] a,
                                             input logic [V_W-1:0] b);
    logic [V_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[V_W]) begin
      sat_add = V_MAX;
    end else begin
      sat_add = sum[V_W-1:0];
    end
  endfunction

endpackage

// File: rtl/lif_update_core.sv
// Combinational LIF membrane update for one neuron: leak, integrate, threshold and refractory.
module lif_update_core
  import lif_pkg::*;
#(
  parameter logic [7:0] THRESHOLD  = 8'd200,
  parameter int         LEAK_SHIFT = 1,
  parameter int         REFRACTORY = 2,
  parameter int         R_W        = 2
) (
  input  logic [V_W-1:0] v_i,
  input  logic [V_W-1:0] pend_i,
  input  logic [R_W-1:0] refr_i,
  output logic [V_W-1:0] v_next_o,
  output logic [R_W-1:0] refr_next_o,
  output logic           fire_o
);

  logic [V_W-1:0] leak_s;

  // v_next_o is the pre-reset potential; the scheduler zeroes stored v on a spike.
  always_comb begin
    leak_s      = v_i - (v_i >> LEAK_SHIFT);
    v_next_o    = {V_W{1'b0}};
    refr_next_o = {R_W{1'b0}};
    fire_o      = 1'b0;
    if (refr_i != {R_W{1'b0}}) begin
      v_next_o    = {V_W{1'b0}};
      refr_next_o = refr_i - R_W'(1);
      fire_o      = 1'b0;
    end else begin
      v_next_o = sat_add(leak_s, pend_i);
      if (v_next_o >= THRESHOLD) begin
        fire_o      = 1'b1;
        refr_next_o = R_W'(REFRACTORY);
      end else begin
        fire_o      = 1'b0;
        refr_next_o = {R_W{1'b0}};
      end
    end
  end

endmodule

// File: rtl/lif_scheduler.sv
// Time-multiplexed LIF scheduler: owns per-neuron state, sweeps on tick, emits spike events.
// Optional dropped-tick counter enabled by defining LIF_OVERRUN_CNT_EN.
module lif_scheduler
  import lif_pkg::*;
#(
  parameter int         N_NEURONS  = 4,
  parameter int         ID_W       = $clog2(N_NEURONS),
  parameter logic [7:0] THRESHOLD  = 8'd200,
  parameter int         LEAK_SHIFT = 1,
  parameter int         REFRACTORY = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            tick,
  input  logic            cur_valid,
  output logic            cur_ready,
  input  logic [ID_W-1:0] cur_id,
  input  logic [7:0]      cur_value,
  output logic            spike_valid,
  input  logic            spike_ready,
  output logic [ID_W-1:0] spike_id,
  output logic [7:0]      state_out,
  output logic            busy,
  output logic [7:0]      overrun_cnt
);

  localparam int              R_W     = (REFRACTORY < 1) ? 1 : $clog2(REFRACTORY + 1);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_NEURONS - 1);

  lif_state_e      state_q, state_d;
  logic [ID_W-1:0] idx_q, idx_d;
  logic            spike_valid_q, spike_valid_d;
  logic [ID_W-1:0] spike_id_q, spike_id_d;
  logic [V_W-1:0]  state_out_q, state_out_d;

  logic [V_W-1:0]  v_q    [N_NEURONS];
  logic [V_W-1:0]  v_d    [N_NEURONS];
  logic [V_W-1:0]  pend_q [N_NEURONS];
  logic [V_W-1:0]  pend_d [N_NEURONS];
  logic [R_W-1:0]  refr_q [N_NEURONS];
  logic [R_W-1:0]  refr_d [N_NEURONS];

  logic [V_W-1:0]  core_v_s;
  logic [R_W-1:0]  core_refr_s;
  logic            core_fire_s;

  lif_update_core #(
    .THRESHOLD  (THRESHOLD),
    .LEAK_SHIFT (LEAK_SHIFT),
    .REFRACTORY (REFRACTORY),
    .R_W        (R_W)
  ) u_core (
    .v_i         (v_q[idx_q]),
    .pend_i      (pend_q[idx_q]),
    .refr_i      (refr_q[idx_q]),
    .v_next_o    (core_v_s),
    .refr_next_o (core_refr_s),
    .fire_o      (core_fire_s)
  );

  // Sequencing and per-neuron next-state selection.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    spike_valid_d = spike_valid_q;
    spike_id_d    = spike_id_q;
    state_out_d   = state_out_q;
    for (int i = 0; i < N_NEURONS; i++) begin
      v_d[i]    = v_q[i];
      pend_d[i] = pend_q[i];
      refr_d[i] = refr_q[i];
    end
    case (state_q)
      IDLE: begin
        // The write lands before UPDATE reads pend, so a same-cycle tick sees it.
        if (cur_valid) begin
          pend_d[cur_id] = sat_add(pend_q[cur_id], cur_value);
        end else begin
          pend_d[cur_id] = pend_q[cur_id];
        end
        if (tick) begin
          state_d = UPDATE;
          idx_d   = {ID_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      UPDATE: begin
        v_d[idx_q]    = core_fire_s ? {V_W{1'b0}} : core_v_s;
        refr_d[idx_q] = core_refr_s;
        pend_d[idx_q] = {V_W{1'b0}};
        state_out_d   = core_v_s;
        if (core_fire_s) begin
          spike_id_d    = idx_q;
          spike_valid_d = 1'b1;
          state_d       = EMIT;
        end else if (idx_q == LAST_ID) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + ID_W'(1);
        end
      end
      EMIT: begin
        if (spike_ready) begin
          spike_valid_d = 1'b0;
          if (idx_q == LAST_ID) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + ID_W'(1);
            state_d = UPDATE;
          end
        end else begin
          spike_valid_d = 1'b1;
        end
      end
      default: begin
        state_d       = IDLE;
        spike_valid_d = 1'b0;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      idx_q         <= {ID_W{1'b0}};
      spike_valid_q <= 1'b0;
      spike_id_q    <= {ID_W{1'b0}};
      state_out_q   <= {V_W{1'b0}};
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      spike_valid_q <= spike_valid_d;
      spike_id_q    <= spike_id_d;
      state_out_q   <= state_out_d;
    end
  end

  // Per-neuron membrane, pending current and refractory storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i]    <= {V_W{1'b0}};
        pend_q[i] <= {V_W{1'b0}};
        refr_q[i] <= {R_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i]    <= v_d[i];
        pend_q[i] <= pend_d[i];
        refr_q[i] <= refr_d[i];
      end
    end
  end

`ifdef LIF_OVERRUN_CNT_EN
  logic [7:0] ovr_q, ovr_d;

  // Counts ticks that arrive while a sweep is still running; sticks at full scale.
  always_comb begin
    ovr_d = ovr_q;
    if (tick && (state_q != IDLE) && (ovr_q != V_MAX)) begin
      ovr_d = ovr_q + 8'd1;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Overrun counter register, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovr_q <= 8'd0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign overrun_cnt = ovr_q;
`else
  assign overrun_cnt = 8'd0;
`endif

  assign cur_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign spike_valid = spike_valid_q;
  assign spike_id    = spike_id_q;
  assign state_out   = state_out_q;

endmodule

// File: tb/tb_lif_scheduler.sv
// Self-checking bench for lif_scheduler: reference model plus spike scoreboard.
module tb_lif_scheduler;

  localparam int N     = 4;
  localparam int THR   = 200;
  localparam int REFR  = 2;

  typedef struct {
    int id;
    int out;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       tick;
  logic       cur_valid;
  logic       cur_ready;
  logic [1:0] cur_id;
  logic [7:0] cur_value;
  logic       spike_valid;
  logic       spike_ready;
  logic [1:0] spike_id;
  logic [7:0] state_out;
  logic       busy;
  logic [7:0] overrun_cnt;

  int   n_chk;
  int   n_err;
  int   m_v    [N];
  int   m_pend [N];
  int   m_refr [N];
  exp_t sb_q   [$];

  lif_scheduler dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick        (tick),
    .cur_valid   (cur_valid),
    .cur_ready   (cur_ready),
    .cur_id      (cur_id),
    .cur_value   (cur_value),
    .spike_valid (spike_valid),
    .spike_ready (spike_ready),
    .spike_id    (spike_id),
    .state_out   (state_out),
    .busy        (busy),
    .overrun_cnt (overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int sat8(input int x);
    return (x > 255) ? 255 : x;
  endfunction

  // Scoreboard: every accepted spike is compared against the oldest prediction.
  always @(negedge clk) begin
    if (reset_n && spike_valid && spike_ready) begin
      exp_t e;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
      end else begin
        e.id  = 255;
        e.out = 32'hFFFF;
      end
      chk("sb_id", 32'(spike_id), e.id);
      chk("sb_out", 32'(state_out), e.out);
    end
  end

  task automatic write_cur(input int id, input int val);
    @(posedge clk); #1;
    cur_valid = 1'b1;
    cur_id    = 2'(id);
    cur_value = 8'(val);
    @(negedge clk);
    chk("cur_ready", 32'(cur_ready), 1);
    @(posedge clk); #1;
    cur_valid = 1'b0;
    m_pend[id] = sat8(m_pend[id] + val);
  endtask

  task automatic run_sweep(input int stall, input int mid_ticks,
                           input bit wr, input int wr_id, input int wr_val);
    int exp_out [N];
    bit exp_fire[N];
    int nx;
    int stall_left;
    int mid_left;
    exp_t e;
    if (wr) m_pend[wr_id] = sat8(m_pend[wr_id] + wr_val);
    for (int i = 0; i < N; i++) begin
      if (m_refr[i] > 0) begin
        exp_out[i]  = 0;
        exp_fire[i] = 1'b0;
        m_v[i]      = 0;
        m_refr[i]   = m_refr[i] - 1;
      end else begin
        nx          = sat8(m_v[i] - (m_v[i] >> 1) + m_pend[i]);
        exp_out[i]  = nx;
        exp_fire[i] = (nx >= THR);
        m_v[i]      = exp_fire[i] ? 0 : nx;
        m_refr[i]   = exp_fire[i] ? REFR : 0;
        if (exp_fire[i]) begin
          e.id  = i;
          e.out = nx;
          sb_q.push_back(e);
        end
      end
      m_pend[i] = 0;
    end
    spike_ready = (stall == 0);
    @(posedge clk); #1;
    tick      = 1'b1;
    cur_valid = wr;
    cur_id    = 2'(wr_id);
    cur_value = 8'(wr_val);
    @(posedge clk); #1;
    tick      = 1'b0;
    cur_valid = 1'b0;
    @(negedge clk);
    chk("busy_start", 32'(busy), 1);
    stall_left = stall;
    mid_left   = mid_ticks;
    for (int i = 0; i < N; i++) begin
      @(posedge clk); #1;
      tick = (mid_left > 0);
      if (mid_left > 0) mid_left--;
      @(negedge clk);
      chk("state_out", 32'(state_out), exp_out[i]);
      chk("spike_valid", 32'(spike_valid), 32'(exp_fire[i]));
      chk("busy", 32'(busy), 32'(exp_fire[i] || (i < N - 1)));
      if (exp_fire[i]) begin
        chk("spike_id", 32'(spike_id), i);
        for (int s = 0; s < stall_left; s++) begin
          @(posedge clk); #1;
          if (s == stall_left - 1) spike_ready = 1'b1;
          @(negedge clk);
          chk("stall_id", 32'(spike_id), i);
          chk("stall_vld", 32'(spike_valid), 1);
          chk("stall_out", 32'(state_out), exp_out[i]);
        end
        stall_left = 0;
        @(posedge clk); #1;
        tick = 1'b0;
      end
    end
    @(posedge clk); #1;
    tick = 1'b0;
    @(negedge clk);
    chk("busy_end", 32'(busy), 0);
    chk("spike_vld_end", 32'(spike_valid), 0);
    chk("sb_drained", 32'(sb_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_ovr;
    n_chk       = 0;
    n_err       = 0;
    reset_n     = 1'b0;
    tick        = 1'b0;
    cur_valid   = 1'b0;
    cur_id      = 2'd0;
    cur_value   = 8'd0;
    spike_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      m_v[i] = 0; m_pend[i] = 0; m_refr[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_spike_valid", 32'(spike_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_state_out", 32'(state_out), 0);
    chk("rst_spike_id", 32'(spike_id), 0);
    chk("rst_overrun", 32'(overrun_cnt), 0);
    chk("rst_cur_ready", 32'(cur_ready), 1);
    reset_n = 1'b1;

    // Neuron 1 fires, then sits out two sweeps, then fires again.
    write_cur(1, 250);
    run_sweep(0, 0, 1'b0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      write_cur(1, 250);
      run_sweep(0, 0, 1'b0, 0, 0);
    end

    // Neuron 0 integrates with leak: 100, 150, 175; mid-sweep ticks on the last one.
    for (int k = 0; k < 3; k++) begin
      write_cur(0, 100);
      run_sweep(0, (k == 2) ? 2 : 0, 1'b0, 0, 0);
    end
`ifdef LIF_OVERRUN_CNT_EN
    exp_ovr = 2;
`else
    exp_ovr = 0;
`endif
    chk("overrun_cnt", 32'(overrun_cnt), exp_ovr);

    // Two spikes in one sweep with a stalled consumer on the first.
    write_cur(0, 220);
    write_cur(3, 220);
    run_sweep(5, 0, 1'b0, 0, 0);

    // Pending current saturates; second write coincides with tick.
    write_cur(2, 200);
    run_sweep(0, 0, 1'b1, 2, 200);

    // Reset asserted while a spike is held in EMIT.
    write_cur(1, 250);
    spike_ready = 1'b0;
    @(posedge clk); #1;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    for (int k = 0; k < 20 && !spike_valid; k++) @(negedge clk);
    chk("emit_seen", 32'(spike_valid), 1);
    chk("emit_id", 32'(spike_id), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_spike_valid", 32'(spike_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_overrun", 32'(overrun_cnt), 0);
    @(posedge clk); #1;
    reset_n     = 1'b1;
    spike_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      m_v[i] = 0; m_pend[i] = 0; m_refr[i] = 0;
    end
    run_sweep(0, 0, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
